uart_echo_xform: RTL and testbench

- Parametrised UART receive/transform/transmit block: deserialises frames on rxd_in, adds a constant offset to each good byte, buffers results in a small FIFO, and reserialises them on txd_out.
- Successor to the fixed 8N1, clock-per-bit echo block. Adds a baud divider, mid-bit sampling, parity, configurable stop bits, error flags and buffering between RX and TX.
- Sits at the board serial pin pair.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_sync_fifo.sv | 63 ++++++
 rtl/uart_echo_xform.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uart_echo_xform.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART echo/transform block.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Parity bit that completes the frame: even parity is the XOR of the
    // data bits, odd parity is its inverse. Callers zero-extend narrow words.
    function automatic logic parity_bit(input logic [7:0] dat, input int mode);
        return (^dat) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO buffering transformed words between the RX and TX engines.
// Latency: a push is visible on dout/empty the cycle after it is written.
// Backpressure: push while full is ignored unless a pop happens in the same
//               cycle; pop while empty is ignored.
//
// Ports: clk_in, rst_n_in (async, active-low); push/din write side;
//        pop/dout read side (dout is the head word, valid when !empty);
//        full, empty, level (occupancy 0..DEPTH).
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign dout    = mem[rd_ptr];
    // A pop frees the slot the simultaneous push needs, so full+pop+push is legal.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_xform.sv
// UART echo: receive frames, add OFFSET to good words, buffer, retransmit.
// Latency: rx fall -> tx start = 2 sync + 1 edge + frame sampling + push + pop + launch.
// Backpressure: none on the line; words arriving with the FIFO full are dropped (fifo_ovf_out).
//
// Ports: clk_in, rst_n_in (async, active-low); rxd_in serial in (async, idle high);
//        txd_out serial out (idle high); rx_parity_err_out, rx_frame_err_out,
//        fifo_ovf_out one-cycle status pulses; tx_busy_out; fifo_level_out occupancy.
module uart_echo_xform
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          DATA_BITS    = 8,
    parameter int          PARITY       = 0,
    parameter int          STOP_BITS    = 1,
    parameter logic [7:0]  OFFSET       = 8'h20,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            rxd_in,
    output logic                            txd_out,
    output logic                            rx_parity_err_out,
    output logic                            rx_frame_err_out,
    output logic                            fifo_ovf_out,
    output logic                            tx_busy_out,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_out
);

    localparam int CW = $clog2(2 * CLKS_PER_BIT);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]        HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]        BIT_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]        STOP_M1  = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [2:0]           LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [DATA_BITS-1:0] OFS      = OFFSET[DATA_BITS-1:0];

    // ---------------- input synchroniser and edge detect ----------------
    logic rx_meta, rx_sync, rx_prev, rx_fall;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rxd_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    // ---------------- RX engine ----------------
    rx_state_t            rx_state, rx_state_n;
    logic [CW-1:0]        rx_cnt, rx_cnt_n;
    logic [2:0]           rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
    logic                 rx_perr, rx_perr_n;
    logic                 push_q, push_n;
    logic [DATA_BITS-1:0] push_dat_q, push_dat_n;
    logic                 perr_pls_q, perr_pls_n;
    logic                 ferr_pls_q, ferr_pls_n;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_perr    <= 1'b0;
            push_q     <= 1'b0;
            push_dat_q <= '0;
            perr_pls_q <= 1'b0;
            ferr_pls_q <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_bit     <= rx_bit_n;
            rx_shift   <= rx_shift_n;
            rx_perr    <= rx_perr_n;
            push_q     <= push_n;
            push_dat_q <= push_dat_n;
            perr_pls_q <= perr_pls_n;
            ferr_pls_q <= ferr_pls_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_perr_n  = rx_perr;
        push_n     = 1'b0;
        push_dat_n = push_dat_q;
        perr_pls_n = 1'b0;
        ferr_pls_n = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_perr_n  = 1'b0;
                end
            end
            RX_START: begin
                // Half-bit sample re-centres the counter on the bit middle.
                if (rx_cnt == HALF_M1) begin
                    rx_cnt_n   = '0;
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_M1) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[DATA_BITS-1:1]};
                    if (rx_bit == LAST_BIT) begin
                        rx_state_n = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_PARITY: begin
                if (rx_cnt == BIT_M1) begin
                    rx_cnt_n   = '0;
                    rx_perr_n  = (rx_sync != parity_bit(8'(rx_shift), PARITY));
                    rx_state_n = RX_STOP;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_M1) begin
                    rx_cnt_n = '0;
                    if (rx_sync) begin
                        rx_state_n = RX_IDLE;
                        if (rx_perr) begin
                            perr_pls_n = 1'b1;
                        end else begin
                            push_n     = 1'b1;
                            push_dat_n = rx_shift + OFS;
                        end
                    end else begin
                        // Framing error wins over parity; wait out a held-low line.
                        ferr_pls_n = 1'b1;
                        rx_state_n = RX_BREAK;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_BREAK: begin
                if (rx_sync) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ---------------- RX -> TX buffer ----------------
    logic                 tx_pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full, fifo_empty;
    logic [LW-1:0]        fifo_level;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .push     (push_q),
        .din      (push_dat_q),
        .pop      (tx_pop),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // ---------------- TX engine ----------------
    tx_state_t            tx_state, tx_state_n;
    logic [CW-1:0]        tx_cnt, tx_cnt_n;
    logic [2:0]           tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 tx_par, tx_par_n;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = fifo_dout;
                    // Parity captured up front since the shifter is consumed.
                    tx_par_n   = parity_bit(8'(fifo_dout), PARITY);
                    tx_cnt_n   = '0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_M1) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_M1) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = tx_shift >> 1;
                    if (tx_bit == LAST_BIT) begin
                        tx_state_n = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_bit_n = tx_bit + 1'b1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            TX_PARITY: begin
                if (tx_cnt == BIT_M1) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_STOP;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == STOP_M1) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_IDLE;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // Line level decoded from registered state only, so reset forces it high at once.
    always_comb begin
        txd_out = 1'b1;
        case (tx_state)
            TX_START:  txd_out = 1'b0;
            TX_DATA:   txd_out = tx_shift[0];
            TX_PARITY: txd_out = tx_par;
            default:   txd_out = 1'b1;
        endcase
    end

    assign rx_parity_err_out = perr_pls_q;
    assign rx_frame_err_out  = ferr_pls_q;
    assign fifo_ovf_out      = push_q & fifo_full & ~tx_pop;
    assign tx_busy_out       = (tx_state != TX_IDLE);
    assign fifo_level_out    = fifo_level;

endmodule

// File: tb/tb_uart_echo_xform.sv
`timescale 1ns/1ps
module tb_uart_echo_xform;

    typedef struct {
        int         idx;
        logic [7:0] dat;
        logic       par;
        logic       stop_ok;
        int         t_start;
    } cap_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rxd;
    wire  [3:0] txd, busy, perr, ferr, ovf;
    wire  [2:0] lvl0, lvl1, lvl2;
    wire  [1:0] lvl3;

    int   cyc = 0;
    int   rst_evt = 0;
    int   t_fall = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_perr[4] = '{0, 0, 0, 0};
    int   n_ferr[4] = '{0, 0, 0, 0};
    int   n_ovf[4]  = '{0, 0, 0, 0};
    int   max_lvl3 = 0;
    cap_t caps[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge rst_n) rst_evt++;

    // u0: 8N1 baseline; u1: 7 data bits; u2: even parity; u3: 2 stop bits, 2-deep FIFO
    uart_echo_xform #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                      .OFFSET(8'h20), .FIFO_DEPTH(4)) u0 (
        .clk_in(clk), .rst_n_in(rst_n), .rxd_in(rxd[0]), .txd_out(txd[0]),
        .rx_parity_err_out(perr[0]), .rx_frame_err_out(ferr[0]), .fifo_ovf_out(ovf[0]),
        .tx_busy_out(busy[0]), .fifo_level_out(lvl0));
    uart_echo_xform #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1),
                      .OFFSET(8'h20), .FIFO_DEPTH(4)) u1 (
        .clk_in(clk), .rst_n_in(rst_n), .rxd_in(rxd[1]), .txd_out(txd[1]),
        .rx_parity_err_out(perr[1]), .rx_frame_err_out(ferr[1]), .fifo_ovf_out(ovf[1]),
        .tx_busy_out(busy[1]), .fifo_level_out(lvl1));
    uart_echo_xform #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                      .OFFSET(8'h20), .FIFO_DEPTH(4)) u2 (
        .clk_in(clk), .rst_n_in(rst_n), .rxd_in(rxd[2]), .txd_out(txd[2]),
        .rx_parity_err_out(perr[2]), .rx_frame_err_out(ferr[2]), .fifo_ovf_out(ovf[2]),
        .tx_busy_out(busy[2]), .fifo_level_out(lvl2));
    uart_echo_xform #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2),
                      .OFFSET(8'h20), .FIFO_DEPTH(2)) u3 (
        .clk_in(clk), .rst_n_in(rst_n), .rxd_in(rxd[3]), .txd_out(txd[3]),
        .rx_parity_err_out(perr[3]), .rx_frame_err_out(ferr[3]), .fifo_ovf_out(ovf[3]),
        .tx_busy_out(busy[3]), .fifo_level_out(lvl3));

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (perr[i] === 1'b1) n_perr[i]++;
            if (ferr[i] === 1'b1) n_ferr[i]++;
            if (ovf[i]  === 1'b1) n_ovf[i]++;
        end
        if (int'(lvl3) > max_lvl3) max_lvl3 = int'(lvl3);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Line decoder: samples each bit at its centre (start seen 0.5 cycle in).
    // Frames cut by a reset are not recorded.
    task automatic mon(input int i, input int db, input bit pen, input int nstop);
        cap_t c;
        int   r0;
        forever begin
            @(negedge clk);
            if (txd[i] === 1'b0 && rst_n === 1'b1) begin
                r0 = rst_evt;
                c.idx = i; c.t_start = cyc; c.dat = '0; c.par = 1'b0; c.stop_ok = 1'b1;
                repeat (2) @(negedge clk);
                for (int j = 0; j < db; j++) begin
                    repeat (4) @(negedge clk);
                    c.dat[j] = txd[i];
                end
                if (pen) begin
                    repeat (4) @(negedge clk);
                    c.par = txd[i];
                end
                for (int j = 0; j < nstop; j++) begin
                    repeat (4) @(negedge clk);
                    if (txd[i] !== 1'b1) c.stop_ok = 1'b0;
                end
                if (rst_evt == r0) caps.push_back(c);
            end
        end
    endtask

    initial fork
        mon(0, 8, 1'b0, 1);
        mon(1, 7, 1'b0, 1);
        mon(2, 8, 1'b1, 1);
        mon(3, 8, 1'b0, 2);
    join

    function automatic int ncap(input int i);
        int n = 0;
        foreach (caps[k]) if (caps[k].idx == i) n++;
        return n;
    endfunction

    function automatic cap_t getcap(input int i, input int nth);
        cap_t r;
        int   n = 0;
        r.idx = -1; r.dat = '0; r.par = 1'b0; r.stop_ok = 1'b0; r.t_start = 0;
        foreach (caps[k]) begin
            if (caps[k].idx == i) begin
                if (n == nth) r = caps[k];
                n++;
            end
        end
        return r;
    endfunction

    // Called at a negedge; ends at a negedge so frames can run back to back.
    task automatic send(input int i, input logic [7:0] d, input int nb,
                        input bit pen, input logic pb, input logic stopv);
        rxd[i] = 1'b0;
        t_fall = cyc;
        repeat (4) @(negedge clk);
        for (int j = 0; j < nb; j++) begin
            rxd[i] = d[j];
            repeat (4) @(negedge clk);
        end
        if (pen) begin
            rxd[i] = pb;
            repeat (4) @(negedge clk);
        end
        rxd[i] = stopv;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cap_t       c;
        logic [7:0] ins [24];
        int         p, bad, lows, n0, t_tx, found;

        rxd   = 4'hF;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd",   txd, 4'hF);
        check("rst_busy",  busy, 4'h0);
        check("rst_lvl0",  lvl0, 3'd0);
        check("rst_lvl3",  lvl3, 2'd0);
        check("rst_pulse", {perr, ferr, ovf}, 12'h000);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single frame 0x41 -> 0x61. Start bit expected 43 cycles after the
        // rx fall: 2 sync + 1 edge + 2 half-bit + 9 bits*4 to stop sample,
        // then push, pop, launch.
        send(0, 8'h41, 8, 1'b0, 1'b0, 1'b1);
        repeat (60) @(negedge clk);
        check("single_cnt", ncap(0), 1);
        c = getcap(0, 0);
        check("single_dat", c.dat, 8'h61);
        check("single_stop", c.stop_ok, 1'b1);
        check("single_lat", c.t_start - t_fall, 43);
        check("single_err", n_perr[0] + n_ferr[0] + n_ovf[0], 0);
        check("single_lvl", lvl0, 3'd0);
        check("single_busy", busy[0], 1'b0);

        // Modulo wrap, 8 and 7 data bits
        send(0, 8'hF0, 8, 1'b0, 1'b0, 1'b1);
        repeat (60) @(negedge clk);
        check("wrap8_cnt", ncap(0), 2);
        c = getcap(0, 1);
        check("wrap8_dat", c.dat, 8'h10);
        send(1, 8'h70, 7, 1'b0, 1'b0, 1'b1);
        repeat (60) @(negedge clk);
        check("wrap7_cnt", ncap(1), 1);
        c = getcap(1, 0);
        check("wrap7_dat", c.dat, 8'h10);

        // Even parity: 0x55 (four ones) carries parity 0; 0x75 (five ones) goes out with 1
        send(2, 8'h55, 8, 1'b1, 1'b0, 1'b1);
        repeat (60) @(negedge clk);
        check("par_ok_cnt", ncap(2), 1);
        c = getcap(2, 0);
        check("par_ok_dat", c.dat, 8'h75);
        check("par_ok_bit", c.par, 1'b1);
        check("par_ok_err", n_perr[2], 0);
        send(2, 8'h55, 8, 1'b1, 1'b1, 1'b1);
        repeat (60) @(negedge clk);
        check("par_bad_err", n_perr[2], 1);
        check("par_bad_cnt", ncap(2), 1);

        // Framing error with line held low for 20 bit times, then recovery
        send(0, 8'h33, 8, 1'b0, 1'b0, 1'b0);
        repeat (76) @(negedge clk);
        check("frm_err", n_ferr[0], 1);
        check("frm_perr", n_perr[0], 0);
        check("frm_quiet", ncap(0), 2);
        check("frm_busy", busy[0], 1'b0);
        rxd[0] = 1'b1;
        repeat (8) @(negedge clk);
        send(0, 8'h41, 8, 1'b0, 1'b0, 1'b1);
        repeat (60) @(negedge clk);
        check("frm_recov_cnt", ncap(0), 3);
        c = getcap(0, 2);
        check("frm_recov_dat", c.dat, 8'h61);
        check("frm_recov_err", n_ferr[0], 1);

        // One-cycle glitch is rejected silently
        rxd[0] = 1'b0;
        @(negedge clk);
        rxd[0] = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_cnt", ncap(0), 3);
        check("glitch_err", n_ferr[0] + n_perr[0], 1);
        check("glitch_lvl", lvl0, 3'd0);

        // Overflow: TX frames are 45 cycles start-to-start against 40-cycle RX
        // frames, so the backlog only outgrows FIFO+shifter after ~16 frames.
        for (int k = 0; k < 24; k++) ins[k] = 8'(k * 9 + 1);
        for (int k = 0; k < 24; k++) send(3, ins[k], 8, 1'b0, 1'b0, 1'b1);
        repeat (250) @(negedge clk);
        check("ovf_seen", (n_ovf[3] >= 1), 1'b1);
        check("ovf_maxlvl", (max_lvl3 <= 2), 1'b1);
        check("ovf_accounting", ncap(3) + n_ovf[3], 24);
        c = getcap(3, 0);
        check("ovf_first", c.dat, ins[0] + 8'h20);
        c = getcap(3, 1);
        check("ovf_second", c.dat, ins[1] + 8'h20);
        p = 0; bad = 0;
        for (int m = 0; m < ncap(3); m++) begin
            c = getcap(3, m);
            if (!c.stop_ok) bad++;
            while (p < 24 && (ins[p] + 8'h20) != c.dat) p++;
            if (p >= 24) bad++;
            else p++;
        end
        check("ovf_order", bad, 0);
        bad = 0;
        for (int m = 1; m < ncap(3); m++) begin
            if (getcap(3, m).t_start - getcap(3, m - 1).t_start != 45) bad++;
        end
        check("ovf_gapless", bad, 0);
        check("ovf_drained", lvl3, 2'd0);

        // Reset during data bit 3 of a TX frame
        send(0, 8'h41, 8, 1'b0, 1'b0, 1'b1);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (txd[0] === 1'b0) found = 1;
            else @(negedge clk);
        end
        check("rstx_started", found, 1);
        t_tx = cyc;
        repeat (18) @(negedge clk);
        check("rstx_midframe", busy[0], 1'b1);
        n0 = ncap(0);
        rst_n = 1'b0;
        #1;
        check("rstx_txd", txd[0], 1'b1);
        check("rstx_busy", busy[0], 1'b0);
        check("rstx_lvl", lvl0, 3'd0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (txd[0] !== 1'b1) lows++;
        end
        check("rstx_no_residual", lows, 0);
        check("rstx_no_capture", ncap(0), n0);
        check("rstx_tstart_seen", (t_tx > 0), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
